// File: rtl/sd_otf_converter_pkg.sv
// Shared definitions for the digit-serial on-the-fly signed-digit converter:
// width derivations, the digit range check and the control FSM state type.
package sd_otf_converter_pkg;

    // Control states: waiting for a word, stepping digits, holding a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } otf_state_t;

    // Bits contributed per digit position (radix is a power of two).
    function automatic int calc_k(input int radix);
        return $clog2(radix);
    endfunction

    // Result width: all digit positions including the carry digit, plus a sign bit.
    function automatic int calc_w(input int no_of_digits, input int radix);
        return (no_of_digits + 1) * $clog2(radix) + 1;
    endfunction

    // A digit is illegal when it is the most negative code or exceeds +/-(radix-1).
    function automatic logic digit_out_of_range(input int d, input int radix_bits, input int radix);
        return (d == -(1 << (radix_bits - 1))) || (d > radix - 1) || (d < -(radix - 1));
    endfunction

endpackage

// File: rtl/sd_otf_converter_otf_step.sv
// Single-digit on-the-fly update: consumes one signed digit and produces the
// next Q (value so far) and QM (value so far minus one) without any carry
// propagation in the Q path; both are pure shift-and-append selections.
module sd_otf_converter_otf_step
    import sd_otf_converter_pkg::*;
#(
    parameter int RADIX_BITS = 4,
    parameter int RADIX      = 8,
    parameter int W          = 16
) (
    input  logic [RADIX_BITS-1:0] i_d,
    input  logic [W-1:0]          i_q,
    input  logic [W-1:0]          i_qm,
    output logic [W-1:0]          o_q,
    output logic [W-1:0]          o_qm,
    output logic                  o_digit_err
);

    localparam int K = calc_k(RADIX);

    logic         w_neg;
    logic         w_pos;
    logic [K-1:0] w_d_low;
    logic [K-1:0] w_d_m1_low;
    logic         w_unused;

    assign w_neg      = i_d[RADIX_BITS-1];
    assign w_pos      = !w_neg && (i_d != '0);
    // Low K bits of d equal d mod r, which is d for d>=0 and r+d for d<0.
    assign w_d_low    = i_d[K-1:0];
    // Low K bits of d-1 equal d-1 for d>0 and r-1+d for d<=0.
    assign w_d_m1_low = i_d[K-1:0] - K'(1);

    // Q: d>=0 appends d to Q, d<0 borrows by appending r+d to QM.
    assign o_q  = w_neg ? {i_qm[W-K-1:0], w_d_low} : {i_q[W-K-1:0], w_d_low};
    // QM: d>0 appends d-1 to Q, otherwise appends r-1+d to QM.
    assign o_qm = w_pos ? {i_q[W-K-1:0], w_d_m1_low} : {i_qm[W-K-1:0], w_d_m1_low};

    assign o_digit_err = digit_out_of_range(int'($signed(i_d)), RADIX_BITS, RADIX);

    // Top K bits shift out each step; they are only sign copies for in-range words.
    assign w_unused = ^{i_q[W-1 -: K], i_qm[W-1 -: K]};

endmodule

// File: rtl/sd_otf_converter.sv
// Digit-serial on-the-fly converter: accepts one redundant signed-digit word
// (carry digit plus no_of_digits sum digits), walks it MSD-first one digit per
// clock and presents the equivalent two's-complement value.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high in IDLE, and in DONE it follows out_ready so a new word
// can be taken on the same edge the previous result is consumed. out_valid,
// dout and dout_err stay stable from the edge they rise until an out_ready
// transfer (or reset).
module sd_otf_converter
    import sd_otf_converter_pkg::*;
#(
    parameter int no_of_digits = 4,
    parameter int radix_bits   = 4,
    parameter int radix        = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [no_of_digits*radix_bits-1:0]          din,
    input  logic [radix_bits-1:0]                       din_carry,
    output logic [calc_w(no_of_digits, radix)-1:0]      dout,
    output logic                                        dout_err,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output otf_state_t                                  o_dbg_state
);

    localparam int W  = calc_w(no_of_digits, radix);
    localparam int ND = no_of_digits + 1;
    localparam int DW = ND * radix_bits;
    localparam int CW = $clog2(ND + 1);

    otf_state_t          r_state;
    logic [DW-1:0]       r_digits;
    logic [CW-1:0]       r_cnt;
    logic [W-1:0]        r_q;
    logic [W-1:0]        r_qm;
    logic                r_err;
    logic [W-1:0]        r_dout;
    logic                r_dout_err;
    logic                r_out_valid;

    logic [radix_bits-1:0] w_cur_digit;
    logic [W-1:0]          w_q_next;
    logic [W-1:0]          w_qm_next;
    logic                  w_digit_err;
    logic                  w_err_next;

    // Most significant remaining digit; the carry digit sits at the top after a load.
    assign w_cur_digit = r_digits[DW-1 -: radix_bits];
    assign w_err_next  = r_err | w_digit_err;

    sd_otf_converter_otf_step #(
        .RADIX_BITS (radix_bits),
        .RADIX      (radix),
        .W          (W)
    ) u_step (
        .i_d         (w_cur_digit),
        .i_q         (r_q),
        .i_qm        (r_qm),
        .o_q         (w_q_next),
        .o_qm        (w_qm_next),
        .o_digit_err (w_digit_err)
    );

    assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign out_valid   = r_out_valid;
    assign dout        = r_dout;
    assign dout_err    = r_dout_err;
    assign o_dbg_state = r_state;

    // Control FSM with the digit register, Q/QM datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_digits    <= '0;
            r_cnt       <= '0;
            r_q         <= '0;
            r_qm        <= '1;
            r_err       <= 1'b0;
            r_dout      <= '0;
            r_dout_err  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_digits <= {din_carry, din};
                        r_q      <= '0;
                        r_qm     <= '1;
                        r_err    <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_q      <= w_q_next;
                    r_qm     <= w_qm_next;
                    r_err    <= w_err_next;
                    r_digits <= r_digits << radix_bits;
                    if (r_cnt == CW'(no_of_digits)) begin
                        r_dout      <= w_q_next;
                        r_dout_err  <= w_err_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_digits <= {din_carry, din};
                            r_q      <= '0;
                            r_qm     <= '1;
                            r_err    <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= ST_CONV;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
